mem_stage_ctrl: RTL

- MEM-stage controller: the consuming end of the EX/MEM pipeline register in the 5-stage MIPS core.
- Accepts EX/MEM control and data, runs a req/ack handshake with a variable-latency data memory, and stalls the front of the pipeline while an access is outstanding.
- Drives the MEM/WB register outputs consumed by the writeback stage.
- Detects misaligned addresses, read/write control conflicts and memory timeouts; reports them through a sticky error code.

---
 rtl/mem_stage_pkg.sv | 16 +
 rtl/mem_stage_ctrl_if.sv | 23 ++
 rtl/mem_stage_ctrl_mem_wb_reg.sv | 34 +++
 rtl/mem_stage_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM-stage controller and its MEM/WB register.
package mem_stage_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_CONFLICT = 2'b11;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory req/ack bus between the MEM-stage controller (master) and data memory (slave).
interface mem_stage_ctrl_if #(
  parameter int ADDR_W = 32
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ack;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack
  );

endinterface

// File: rtl/mem_stage_ctrl_mem_wb_reg.sv
// MEM/WB pipeline register; a bubble loads an all-zero entry so nothing is written back.
module mem_wb_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        bubble,
  input  logic        reg_write,
  input  logic        mem_to_reg,
  input  logic [31:0] alu_result,
  input  logic [4:0]  write_reg,
  input  logic [31:0] read_data,
  output logic        wb_reg_write,
  output logic        wb_mem_to_reg,
  output logic [31:0] wb_read_data,
  output logic [31:0] wb_alu_result,
  output logic [4:0]  wb_write_reg
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst || bubble) begin
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_read_data  <= '0;
      wb_alu_result <= '0;
      wb_write_reg  <= '0;
    end else begin
      wb_reg_write  <= reg_write;
      wb_mem_to_reg <= mem_to_reg;
      wb_read_data  <= read_data;
      wb_alu_result <= alu_result;
      wb_write_reg  <= write_reg;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues data-memory requests, stalls the front end while one is
// outstanding, feeds the MEM/WB register and latches the first detected error.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int ADDR_W         = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             alu_result,
  input  logic [4:0]              write_reg,
  input  logic [31:0]             store_data,
  input  logic                    reg_write,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic                    mem_to_reg,
  mem_stage_ctrl_if.master        dmem,
  output logic                    stall,
  output logic                    wb_reg_write,
  output logic                    wb_mem_to_reg,
  output logic [31:0]             wb_read_data,
  output logic [31:0]             wb_alu_result,
  output logic [4:0]              wb_write_reg,
  output logic [1:0]              err_code
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      next_state;
  logic [7:0]  wait_cnt;
  logic        access;
  logic        conflict;
  logic        misaligned;
  logic        legal;
  logic        timeout_hit;
  logic        stall_raw;
  logic        bubble;
  logic        issue;
  logic        finish;
  logic [31:0] read_data;
  logic [1:0]  err_next;

  assign access      = mem_read | mem_write;
  assign conflict    = mem_read & mem_write;
  assign misaligned  = (alu_result[1:0] != 2'b00);
  assign legal       = access & ~misaligned & ~conflict;
  assign timeout_hit = (wait_cnt == TIMEOUT_LAST);

  // Stall is forced low during reset so the front end releases immediately.
  assign stall = stall_raw & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      err_code <= ERR_NONE;
    end else begin
      state    <= next_state;
      err_code <= err_next;
      if (state == ACCESS && !finish) begin
        wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  always_comb begin
    next_state = state;
    stall_raw  = 1'b0;
    bubble     = 1'b1;
    issue      = 1'b0;
    finish     = 1'b0;
    read_data  = '0;
    err_next   = err_code;
    case (state)
      IDLE: begin
        if (!access) begin
          bubble = 1'b0;
        end else if (legal) begin
          stall_raw  = 1'b1;
          issue      = 1'b1;
          next_state = ACCESS;
        end else if (err_code == ERR_NONE) begin
          err_next = conflict ? ERR_CONFLICT : ERR_MISALIGN;
        end
      end
      ACCESS: begin
        // An ack in the timeout cycle still counts as a normal completion.
        if (dmem.ack) begin
          bubble     = 1'b0;
          finish     = 1'b1;
          next_state = IDLE;
          if (!dmem.we) begin
            read_data = dmem.rdata;
          end
        end else if (timeout_hit) begin
          finish     = 1'b1;
          next_state = IDLE;
          if (err_code == ERR_NONE) begin
            err_next = ERR_TIMEOUT;
          end
        end else begin
          stall_raw = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem.req   <= 1'b0;
      dmem.we    <= 1'b0;
      dmem.addr  <= '0;
      dmem.wdata <= '0;
    end else if (issue) begin
      dmem.req   <= 1'b1;
      dmem.we    <= mem_write;
      dmem.addr  <= {alu_result[ADDR_W-1:2], 2'b00};
      dmem.wdata <= store_data;
    end else if (finish) begin
      dmem.req   <= 1'b0;
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk           (clk),
    .rst           (rst),
    .bubble        (bubble),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .alu_result    (alu_result),
    .write_reg     (write_reg),
    .read_data     (read_data),
    .wb_reg_write  (wb_reg_write),
    .wb_mem_to_reg (wb_mem_to_reg),
    .wb_read_data  (wb_read_data),
    .wb_alu_result (wb_alu_result),
    .wb_write_reg  (wb_write_reg)
  );

endmodule
